// File: rtl/dadda_mul_arbiter.sv
// dadda_mul_arbiter: two requesters share one combinational 8x8 unsigned
// Dadda multiplier. A round-robin arbiter accepts one request at a time. The
// operands are registered, the product is captured one cycle later, and the
// result is held on a single port until the consumer takes it.
module dadda_mul_arbiter #(
    parameter logic RR_INIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    output logic        req1_ready,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_product,
    output logic        res_id,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic        op_id;
    logic        last_grant;
    logic        grant_valid;
    logic        grant_id;
    logic [15:0] tree_product;

    // Round-robin grant: a lone request wins; under contention the requester
    // that was not served last wins.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, or a latch is inferred.
        grant_valid = req0_valid | req1_valid;
        grant_id    = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    end

    // Ready depends on valid through the grant, so valid must never wait on ready.
    assign req0_ready = (state == IDLE) && grant_valid && !grant_id;
    assign req1_ready = (state == IDLE) && grant_valid &&  grant_id;

    // Dadda tree: the 64 partial-product bits are reduced column by column to
    // heights 6, 4, 3 and 2. A column is cut only down to the stage height. Bits
    // are cut with a half adder when one bit over the height, and otherwise with
    // a full adder. Two rows remain, and one carry-propagate add finishes the job.
    always_comb begin : dadda_tree
        logic        cur  [16][8];
        logic        nxt  [16][8];
        int          cnt  [16];
        int          ncnt [16];
        int          idx;
        int          height;
        int          d;
        logic [15:0] row_a;
        logic [15:0] row_b;

        idx    = 0;
        height = 0;
        d      = 0;
        row_a  = '0;
        row_b  = '0;
        for (int c = 0; c < 16; c++) begin
            cnt[c]  = 0;
            ncnt[c] = 0;
            for (int k = 0; k < 8; k++) begin
                cur[c][k] = 1'b0;
                nxt[c][k] = 1'b0;
            end
        end

        // Partial products: bit a[i]&b[j] has weight i+j.
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                cur[i+j][cnt[i+j]] = op_a[i] & op_b[j];
                cnt[i+j]           = cnt[i+j] + 1;
            end
        end

        for (int s = 0; s < 4; s++) begin
            case (s)
                0:       d = 6;
                1:       d = 4;
                2:       d = 3;
                default: d = 2;
            endcase
            for (int c = 0; c < 16; c++) begin
                ncnt[c] = 0;
                for (int k = 0; k < 8; k++) begin
                    nxt[c][k] = 1'b0;
                end
            end
            for (int c = 0; c < 16; c++) begin
                idx = 0;
                // Height counts unreduced bits plus sums and carries already
                // placed in this column during this stage.
                for (int k = 0; k < 8; k++) begin
                    height = cnt[c] - idx + ncnt[c];
                    if (height > d) begin
                        if (height == d + 1) begin
                            nxt[c][ncnt[c]] = cur[c][idx] ^ cur[c][idx+1];
                            ncnt[c]         = ncnt[c] + 1;
                            if (c < 15) begin
                                nxt[c+1][ncnt[c+1]] = cur[c][idx] & cur[c][idx+1];
                                ncnt[c+1]           = ncnt[c+1] + 1;
                            end
                            idx = idx + 2;
                        end else begin
                            nxt[c][ncnt[c]] = cur[c][idx] ^ cur[c][idx+1] ^ cur[c][idx+2];
                            ncnt[c]         = ncnt[c] + 1;
                            if (c < 15) begin
                                nxt[c+1][ncnt[c+1]] = (cur[c][idx]   & cur[c][idx+1]) |
                                                      (cur[c][idx]   & cur[c][idx+2]) |
                                                      (cur[c][idx+1] & cur[c][idx+2]);
                                ncnt[c+1]           = ncnt[c+1] + 1;
                            end
                            idx = idx + 3;
                        end
                    end
                end
                // Bits that need no reduction pass straight through.
                for (int k = 0; k < 8; k++) begin
                    if (k >= idx && k < cnt[c]) begin
                        nxt[c][ncnt[c]] = cur[c][k];
                        ncnt[c]         = ncnt[c] + 1;
                    end
                end
            end
            cur = nxt;
            cnt = ncnt;
        end

        // Unused slots are zero, so the two remaining rows can be read directly.
        for (int c = 0; c < 16; c++) begin
            row_a[c] = cur[c][0];
            row_b[c] = cur[c][1];
        end
        tree_product = row_a + row_b;
    end

    // Control FSM: accept in IDLE, capture the product in MUL, hold it in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_a        <= '0;
            op_b        <= '0;
            op_id       <= 1'b0;
            last_grant  <= RR_INIT;
            res_valid   <= 1'b0;
            res_product <= '0;
            res_id      <= 1'b0;
            busy        <= 1'b0;
        end else begin
            // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        op_a       <= grant_id ? req1_a : req0_a;
                        op_b       <= grant_id ? req1_b : req0_b;
                        op_id      <= grant_id;
                        last_grant <= grant_id;
                        state      <= MUL;
                        busy       <= 1'b1;
                    end
                end
                MUL: begin
                    res_product <= tree_product;
                    res_id      <= op_id;
                    res_valid   <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
